// File: rtl/ntt_pass_scheduler.sv
// Pass/group sequencer for an N-point NTT/INTT on the 8-lane radix-8/4/2 datapath:
// generates per-cycle read/write lane addresses, bank selects, twiddle address and radix mode.
module ntt_pass_scheduler #(
  parameter int unsigned LOGN   = 8,
  parameter int unsigned DP_LAT = 2,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              ntt_intt_mode_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              rd_en_o,
  output logic [8*LOGN-1:0] rd_addr_o,
  output logic              rd_bank_o,
  output logic              wr_en_o,
  output logic [8*LOGN-1:0] wr_addr_o,
  output logic              wr_bank_o,
  output logic [LOGN-1:0]   tw_addr_o,
  output logic [1:0]        select_mode_o,
  output logic              ntt_intt_mode_out_o,
  output logic              result_bank_o
);

  localparam int unsigned Lat     = RD_LAT + DP_LAT;
  localparam int unsigned NumPass = (LOGN + 2) / 3;
  localparam int unsigned KLast   = LOGN - 3 * (NumPass - 1);
  localparam int unsigned GrpW    = (LOGN > 3) ? LOGN - 3 : 1;
  localparam int unsigned CntW    = (Lat > 1) ? $clog2(Lat) : 1;

  localparam logic [GrpW-1:0] GLast = GrpW'((1 << (LOGN - 3)) - 1);
  localparam logic [2:0]      PLast = 3'(NumPass - 1);
  localparam logic [CntW-1:0] CLast = CntW'(Lat - 1);
  localparam logic            RBank = 1'(NumPass % 2);

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StDrain,
    StNext,
    StDone
  } state_e;

  state_e          state_q, state_d;
  logic [2:0]      p_q, p_d;
  logic [GrpW-1:0] g_q, g_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            mode_q, mode_d;
  logic            result_bank_q, result_bank_d;

  logic              busy_q, done_q, rd_en_q, rd_bank_q, wr_bank_q;
  logic [8*LOGN-1:0] rd_addr_q, rd_addr_d;
  logic [LOGN-1:0]   tw_addr_q, tw_addr_d;
  logic [1:0]        select_mode_q, select_mode_d;
  logic              issue_d, busy_d;

  logic              wr_v_q [Lat];
  logic [8*LOGN-1:0] wr_a_q [Lat];

  // Butterfly field of pass p holds lane bits j[k-1:0]; {g, j[2:k]} fills the rest MSB-first.
  function automatic logic [LOGN-1:0] lane_addr(input logic [2:0]      p,
                                                input logic [GrpW-1:0] g,
                                                input logic [2:0]      j);
    int unsigned     k, lo;
    logic [LOGN-1:0] w, jf, lo_mask;
    k         = (p == PLast) ? KLast : 32'd3;
    lo        = LOGN - 3 * 32'(p) - k;
    w         = LOGN'({g, j} >> k);
    lo_mask   = {LOGN{1'b1}} >> (LOGN - lo);
    jf        = LOGN'(j & (3'b111 >> (3 - k)));
    lane_addr = ((w >> lo) << (lo + k)) | (jf << lo) | (w & lo_mask);
  endfunction

  function automatic logic [1:0] radix_of(input logic [2:0] p);
    int unsigned k;
    k = (p == PLast) ? KLast : 32'd3;
    unique case (k)
      32'd3:   radix_of = 2'b10;
      32'd2:   radix_of = 2'b01;
      default: radix_of = 2'b00;
    endcase
  endfunction

  always_comb begin
    state_d       = state_q;
    p_d           = p_q;
    g_d           = g_q;
    cnt_d         = cnt_q;
    mode_d        = mode_q;
    result_bank_d = result_bank_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StIssue;
          p_d     = '0;
          g_d     = '0;
          mode_d  = ntt_intt_mode_i;
        end
      end
      StIssue: begin
        if (g_q == GLast) begin
          g_d     = '0;
          cnt_d   = '0;
          state_d = StDrain;
        end else begin
          g_d = g_q + GrpW'(1);
        end
      end
      StDrain: begin
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CLast) begin
          state_d = (p_q == PLast) ? StDone : StNext;
        end
      end
      StNext: begin
        p_d     = p_q + 3'd1;
        g_d     = '0;
        state_d = StIssue;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (state_d == StDone) begin
      result_bank_d = RBank;
    end
  end

  always_comb begin
    issue_d   = (state_d == StIssue);
    busy_d    = (state_d != StIdle);
    rd_addr_d = '0;
    for (int unsigned j = 0; j < 8; j++) begin
      rd_addr_d[j*LOGN +: LOGN] = issue_d ? lane_addr(p_d, g_d, 3'(j)) : '0;
    end
    tw_addr_d = '0;
    if (issue_d) begin
      tw_addr_d = (LOGN > 3) ? LOGN'({p_d, g_d}) : LOGN'(p_d);
    end
    select_mode_d = busy_d ? radix_of(p_d) : 2'b00;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= StIdle;
      p_q           <= '0;
      g_q           <= '0;
      cnt_q         <= '0;
      mode_q        <= 1'b0;
      result_bank_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      rd_en_q       <= 1'b0;
      rd_addr_q     <= '0;
      rd_bank_q     <= 1'b0;
      wr_bank_q     <= 1'b0;
      tw_addr_q     <= '0;
      select_mode_q <= 2'b00;
      for (int unsigned i = 0; i < Lat; i++) begin
        wr_v_q[i] <= 1'b0;
        wr_a_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      p_q           <= p_d;
      g_q           <= g_d;
      cnt_q         <= cnt_d;
      mode_q        <= mode_d;
      result_bank_q <= result_bank_d;
      busy_q        <= busy_d;
      done_q        <= (state_d == StDone);
      rd_en_q       <= issue_d;
      rd_addr_q     <= rd_addr_d;
      rd_bank_q     <= busy_d ? p_d[0] : 1'b0;
      wr_bank_q     <= busy_d ? ~p_d[0] : 1'b0;
      tw_addr_q     <= tw_addr_d;
      select_mode_q <= select_mode_d;
      // Write-back pipe: the last stage is the registered write strobe/address.
      wr_v_q[0] <= rd_en_q;
      wr_a_q[0] <= rd_addr_q;
      for (int unsigned i = 1; i < Lat; i++) begin
        wr_v_q[i] <= wr_v_q[i-1];
        wr_a_q[i] <= wr_a_q[i-1];
      end
    end
  end

  assign busy_o              = busy_q;
  assign done_o              = done_q;
  assign rd_en_o             = rd_en_q;
  assign rd_addr_o           = rd_addr_q;
  assign rd_bank_o           = rd_bank_q;
  assign wr_en_o             = wr_v_q[Lat-1];
  assign wr_addr_o           = wr_a_q[Lat-1];
  assign wr_bank_o           = wr_bank_q;
  assign tw_addr_o           = tw_addr_q;
  assign select_mode_o       = select_mode_q;
  assign ntt_intt_mode_out_o = mode_q;
  assign result_bank_o       = result_bank_q;

endmodule

// File: tb/tb_ntt_pass_scheduler.sv
// Scoreboard bench for ntt_pass_scheduler: LOGN=8 (NTT) and LOGN=6 (INTT) instances,
// expected reads/writes/done queued at start, popped by a negedge monitor.
module tb_ntt_pass_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start_a, start_b, mode_a, mode_b;

  logic        busy_a, done_a, rd_en_a, rd_bank_a, wr_en_a, wr_bank_a, mout_a, rbank_a;
  logic [63:0] rd_addr_a, wr_addr_a;
  logic [7:0]  tw_a;
  logic [1:0]  sel_a;

  logic        busy_b, done_b, rd_en_b, rd_bank_b, wr_en_b, wr_bank_b, mout_b, rbank_b;
  logic [47:0] rd_addr_b, wr_addr_b;
  logic [5:0]  tw_b;
  logic [1:0]  sel_b;

  ntt_pass_scheduler #(.LOGN(8), .DP_LAT(2), .RD_LAT(1)) dut_a (
    .clk_i(clk), .rst_i(rst), .start_i(start_a), .ntt_intt_mode_i(mode_a),
    .busy_o(busy_a), .done_o(done_a), .rd_en_o(rd_en_a), .rd_addr_o(rd_addr_a),
    .rd_bank_o(rd_bank_a), .wr_en_o(wr_en_a), .wr_addr_o(wr_addr_a), .wr_bank_o(wr_bank_a),
    .tw_addr_o(tw_a), .select_mode_o(sel_a), .ntt_intt_mode_out_o(mout_a),
    .result_bank_o(rbank_a)
  );

  ntt_pass_scheduler #(.LOGN(6), .DP_LAT(2), .RD_LAT(1)) dut_b (
    .clk_i(clk), .rst_i(rst), .start_i(start_b), .ntt_intt_mode_i(mode_b),
    .busy_o(busy_b), .done_o(done_b), .rd_en_o(rd_en_b), .rd_addr_o(rd_addr_b),
    .rd_bank_o(rd_bank_b), .wr_en_o(wr_en_b), .wr_addr_o(wr_addr_b), .wr_bank_o(wr_bank_b),
    .tw_addr_o(tw_b), .select_mode_o(sel_b), .ntt_intt_mode_out_o(mout_b),
    .result_bank_o(rbank_b)
  );

  typedef struct {
    int           cyc;
    logic [119:0] addr;
    logic         bank;
    logic [14:0]  tw;
    logic [1:0]   sel;
  } ev_t;

  ev_t rdq_a[$], wrq_a[$], dnq_a[$], rdq_b[$], wrq_b[$], dnq_b[$];

  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   t0    = 0;
  logic exp_mode_a = 1'b0;
  logic exp_mode_b = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc - t0);
    end
  endtask

  // Address tables worked out by hand for the two transform sizes used here.
  function automatic int hand_addr(input int logn, input int p, input int g, input int j);
    if (logn == 8) begin
      case (p)
        0:       return j * 32 + g;
        1:       return ((g >> 2) << 5) | (j << 2) | (g & 3);
        default: return g * 8 + j;
      endcase
    end
    return (p == 0) ? j * 8 + g : g * 8 + j;
  endfunction

  task automatic push_run(input int logn, input int limit, input bit b);
    int  np, ng, per;
    ev_t e;
    np  = (logn + 2) / 3;
    ng  = 1 << (logn - 3);
    per = ng + 4;
    for (int p = 0; p < np; p++) begin
      for (int g = 0; g < ng; g++) begin
        e.cyc  = 1 + per * p + g;
        e.addr = '0;
        for (int j = 0; j < 8; j++) begin
          e.addr = e.addr | (120'(hand_addr(logn, p, g, j)) << (j * logn));
        end
        e.bank = 1'(p % 2);
        e.tw   = 15'((p << (logn - 3)) | g);
        e.sel  = (logn == 8 && p == 2) ? 2'b01 : 2'b10;
        if (e.cyc <= limit) begin
          if (b) rdq_b.push_back(e); else rdq_a.push_back(e);
        end
        e.cyc  = e.cyc + 3;
        e.bank = ~e.bank;
        if (e.cyc <= limit) begin
          if (b) wrq_b.push_back(e); else wrq_a.push_back(e);
        end
      end
    end
    e.cyc  = np * per;
    e.bank = (logn == 8);
    e.addr = '0;
    e.tw   = '0;
    e.sel  = '0;
    if (e.cyc <= limit) begin
      if (b) dnq_b.push_back(e); else dnq_a.push_back(e);
    end
  endtask

  task automatic mon_rd(input bit b, input int rel, input logic [119:0] addr, input logic bank,
                        input logic [14:0] tw, input logic [1:0] sel);
    ev_t e;
    n_cmp++;
    if ((b && rdq_b.size() == 0) || (!b && rdq_a.size() == 0)) begin
      n_err++;
      $display("FAIL rd_%0d unexpected read at cycle %0d addr %h", b, rel, addr);
      return;
    end
    if (b) e = rdq_b.pop_front(); else e = rdq_a.pop_front();
    if (e.cyc != rel || e.addr != addr || e.bank != bank || e.tw != tw || e.sel != sel) begin
      n_err++;
      $display("FAIL rd_%0d: got cyc %0d addr %h bank %0d tw %h sel %b, expected cyc %0d addr %h bank %0d tw %h sel %b",
               b, rel, addr, bank, tw, sel, e.cyc, e.addr, e.bank, e.tw, e.sel);
    end
  endtask

  task automatic mon_wr(input bit b, input int rel, input logic [119:0] addr, input logic bank);
    ev_t e;
    n_cmp++;
    if ((b && wrq_b.size() == 0) || (!b && wrq_a.size() == 0)) begin
      n_err++;
      $display("FAIL wr_%0d unexpected write at cycle %0d addr %h", b, rel, addr);
      return;
    end
    if (b) e = wrq_b.pop_front(); else e = wrq_a.pop_front();
    if (e.cyc != rel || e.addr != addr || e.bank != bank) begin
      n_err++;
      $display("FAIL wr_%0d: got cyc %0d addr %h bank %0d, expected cyc %0d addr %h bank %0d",
               b, rel, addr, bank, e.cyc, e.addr, e.bank);
    end
  endtask

  task automatic mon_done(input bit b, input int rel, input logic rbank);
    ev_t e;
    n_cmp++;
    if ((b && dnq_b.size() == 0) || (!b && dnq_a.size() == 0)) begin
      n_err++;
      $display("FAIL done_%0d unexpected at cycle %0d", b, rel);
      return;
    end
    if (b) e = dnq_b.pop_front(); else e = dnq_a.pop_front();
    if (e.cyc != rel || e.bank != rbank) begin
      n_err++;
      $display("FAIL done_%0d: got cyc %0d result_bank %0d, expected cyc %0d result_bank %0d",
               b, rel, rbank, e.cyc, e.bank);
    end
  endtask

  always @(negedge clk) begin
    int rel;
    rel = cyc - t0;
    if (rd_en_a) mon_rd(1'b0, rel, 120'(rd_addr_a), rd_bank_a, 15'(tw_a), sel_a);
    if (wr_en_a) mon_wr(1'b0, rel, 120'(wr_addr_a), wr_bank_a);
    if (done_a)  mon_done(1'b0, rel, rbank_a);
    if (busy_a)  check("mode_out_a", 256'(mout_a), 256'(exp_mode_a));
    if (rd_en_b) mon_rd(1'b1, rel, 120'(rd_addr_b), rd_bank_b, 15'(tw_b), sel_b);
    if (wr_en_b) mon_wr(1'b1, rel, 120'(wr_addr_b), wr_bank_b);
    if (done_b)  mon_done(1'b1, rel, rbank_b);
    if (busy_b)  check("mode_out_b", 256'(mout_b), 256'(exp_mode_b));
  end

  task automatic wait_rel(input int target);
    while (cyc - t0 < target) @(negedge clk);
  endtask

  task automatic wait_done(input bit b, input string name);
    int n;
    n = 0;
    while (((b && !done_b) || (!b && !done_a)) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check(name, 256'(b ? done_b : done_a), 256'(1));
  endtask

  task automatic begin_run(input logic m);
    @(negedge clk);
    t0         = cyc;
    exp_mode_a = m;
    mode_a     = m;
    start_a    = 1'b1;
  endtask

  initial begin
    rst = 1'b1; start_a = 1'b1; start_b = 1'b1; mode_a = 1'b1; mode_b = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0; start_a = 1'b0; start_b = 1'b0; mode_a = 1'b0; mode_b = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_outputs_a", 256'({busy_a, done_a, rd_en_a, rd_bank_a, wr_en_a, wr_bank_a, mout_a,
          rbank_a, sel_a, tw_a, rd_addr_a, wr_addr_a}), '0);
    check("idle_outputs_b", 256'({busy_b, done_b, rd_en_b, rd_bank_b, wr_en_b, wr_bank_b, mout_b,
          rbank_b, sel_b, tw_b, rd_addr_b, wr_addr_b}), '0);

    // Run 1: LOGN=8 NTT and LOGN=6 INTT started together.
    push_run(8, 1 << 20, 1'b0);
    push_run(6, 1 << 20, 1'b1);
    exp_mode_b = 1'b1;
    begin_run(1'b0);
    start_b = 1'b1; mode_b = 1'b1;
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0; mode_b = 1'b0;
    wait_done(1'b1, "done_b_seen");
    check("done_b_cycle", 256'(cyc - t0), 256'(24));
    @(negedge clk);
    check("busy_b_after_done", 256'(busy_b), '0);
    check("result_bank_b_held", 256'(rbank_b), '0);
    wait_done(1'b0, "done_a_seen");
    check("done_a_cycle", 256'(cyc - t0), 256'(108));
    @(negedge clk);
    check("busy_a_after_done", 256'(busy_a), '0);
    check("result_bank_a_held", 256'(rbank_a), 256'(1));

    // Run 2: a start pulse mid-run must be ignored.
    push_run(8, 1 << 20, 1'b0);
    begin_run(1'b0);
    @(negedge clk);
    start_a = 1'b0;
    wait_rel(50);
    start_a = 1'b1; mode_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0; mode_a = 1'b0;
    wait_done(1'b0, "done_a_run2_seen");
    check("done_a_run2_cycle", 256'(cyc - t0), 256'(108));
    @(negedge clk);
    check("busy_a_run2_after_done", 256'(busy_a), '0);

    // Run 3: reset at cycle 40 aborts the run.
    push_run(8, 40, 1'b0);
    begin_run(1'b0);
    @(negedge clk);
    start_a = 1'b0;
    wait_rel(40);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 256'(busy_a), '0);
    check("abort_rd_wr", 256'({rd_en_a, wr_en_a, done_a}), '0);
    repeat (60) @(negedge clk);
    check("abort_queue_empty", 256'(rdq_a.size() + wrq_a.size() + dnq_a.size()), '0);

    // Run 4: clean run after the abort, with directed address spots.
    push_run(8, 1 << 20, 1'b0);
    begin_run(1'b0);
    @(negedge clk);
    start_a = 1'b0;
    wait_rel(42);
    check("p1_g5_lane3_rd", 256'(rd_addr_a[3*8 +: 8]), 256'(8'h2d));
    wait_rel(45);
    check("p1_g5_lane3_wr", 256'(wr_addr_a[3*8 +: 8]), 256'(8'h2d));
    wait_rel(78);
    check("p2_g5_lane6_rd", 256'(rd_addr_a[6*8 +: 8]), 256'(8'h2e));
    check("p2_select_mode", 256'(sel_a), 256'(2'b01));
    wait_done(1'b0, "done_a_run4_seen");
    check("done_a_run4_cycle", 256'(cyc - t0), 256'(108));
    check("result_bank_a_run4", 256'(rbank_a), 256'(1));
    repeat (5) @(negedge clk);

    check("queues_empty_a", 256'(rdq_a.size() + wrq_a.size() + dnq_a.size()), '0);
    check("queues_empty_b", 256'(rdq_b.size() + wrq_b.size() + dnq_b.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
